// File: rtl/gpr_bank_shadow_checker.sv
// rtl/gpr_bank_shadow_checker.sv - shadow-model read checker for the multi-bank GPR file
//
// Purpose:
//   Keeps a shadow copy of every GPR bank/set, updated from the bank write
//   strobes with per-byte enables, together with a per-byte "written" bit.
//   Each read strobe captures a predicted value plus a compare mask (the
//   written bits of that entry). The prediction travels down a RD_LATENCY
//   deep pipeline so it lines up with the DUT read data. When it emerges,
//   the masked bytes are compared. The results are registered, so a
//   comparison is reported RD_LATENCY+1 cycles after the read strobe.
//
// Build option:
//   GPR_CHK_WRITE_FIRST_EN - a read and a write to the same bank/set in the
//   same cycle predict the merged (new where byte-enabled, old elsewhere)
//   value and mask. When the macro is undefined the checker is read-first.
//
// Ports:
//   clk_i           clock
//   reset_i         synchronous active-high reset
//   wr_en_i         per-bank write strobe
//   wr_set_i        per-bank write set index, bank b at slice b
//   wr_data_i       per-bank write data
//   wr_byteen_i     per-bank byte enables, 1 = byte written
//   rd_en_i         per-bank read strobe
//   rd_set_i        per-bank read set index
//   dut_rd_data_i   DUT read data, valid RD_LATENCY cycles after rd_en_i
//   chk_valid_o     per-bank: a comparison was performed this cycle
//   chk_mismatch_o  per-bank: the comparison failed this cycle
//   err_sticky_o    set on any mismatch, cleared only by reset
//   err_bank_o      lowest failing bank of the first mismatch
//   err_set_o       set index of the first mismatch
//   check_count_o   total comparisons, saturating
//   error_count_o   total mismatching comparisons, saturating
//   uninit_count_o  reads touching never-written bytes, saturating
//
// LANE_W must be a multiple of 8 and RD_LATENCY must be in 1..4.

module gpr_bank_shadow_checker #(
  parameter int NUM_BANKS  = 4,
  parameter int NUM_SETS   = 32,
  parameter int NUM_LANES  = 4,
  parameter int LANE_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16,
  localparam int SET_W     = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int DW        = NUM_LANES * LANE_W,
  localparam int BW        = DW / 8,
  localparam int EB_W      = $clog2(NUM_BANKS) + 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NUM_BANKS-1:0]       wr_en_i,
  input  logic [NUM_BANKS*SET_W-1:0] wr_set_i,
  input  logic [NUM_BANKS*DW-1:0]    wr_data_i,
  input  logic [NUM_BANKS*BW-1:0]    wr_byteen_i,
  input  logic [NUM_BANKS-1:0]       rd_en_i,
  input  logic [NUM_BANKS*SET_W-1:0] rd_set_i,
  input  logic [NUM_BANKS*DW-1:0]    dut_rd_data_i,
  output logic [NUM_BANKS-1:0]       chk_valid_o,
  output logic [NUM_BANKS-1:0]       chk_mismatch_o,
  output logic                       err_sticky_o,
  output logic [EB_W-1:0]            err_bank_o,
  output logic [SET_W-1:0]           err_set_o,
  output logic [CNT_W-1:0]           check_count_o,
  output logic [CNT_W-1:0]           error_count_o,
  output logic [CNT_W-1:0]           uninit_count_o
);

  localparam int PC_W = $clog2(NUM_BANKS + 1);
  localparam int LAST = RD_LATENCY - 1;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [PC_W-1:0] popcnt(input logic [NUM_BANKS-1:0] v);
    logic [PC_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      r = r + PC_W'(v[i]);
    end
    return r;
  endfunction

  // The increment is at most NUM_BANKS, so a carry out of CNT_W bits is the
  // only way to exceed the maximum; clamp there instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PC_W-1:0]  inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(inc);
    if (s[CNT_W]) begin
      return '1;
    end
    return s[CNT_W-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Per-bank views of the flattened buses
  // ---------------------------------------------------------------------------
  logic [SET_W-1:0] wr_set_a  [NUM_BANKS];
  logic [SET_W-1:0] rd_set_a  [NUM_BANKS];
  logic [DW-1:0]    wr_data_a [NUM_BANKS];
  logic [BW-1:0]    wr_be_a   [NUM_BANKS];
  logic [DW-1:0]    dut_a     [NUM_BANKS];

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      wr_set_a[b]  = wr_set_i[b*SET_W +: SET_W];
      rd_set_a[b]  = rd_set_i[b*SET_W +: SET_W];
      wr_data_a[b] = wr_data_i[b*DW +: DW];
      wr_be_a[b]   = wr_byteen_i[b*BW +: BW];
      dut_a[b]     = dut_rd_data_i[b*DW +: DW];
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow storage. Data is never reset: the written bits are, and they gate
  // every comparison, so stale data after reset is never looked at.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] shadow_q  [NUM_BANKS][NUM_SETS];
  logic [BW-1:0] written_q [NUM_BANKS][NUM_SETS];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_en_i[b]) begin
        for (int j = 0; j < BW; j++) begin
          if (wr_be_a[b][j]) begin
            shadow_q[b][wr_set_a[b]][j*8 +: 8] <= wr_data_a[b][j*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          written_q[b][s] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (wr_en_i[b]) begin
          written_q[b][wr_set_a[b]] <= written_q[b][wr_set_a[b]] | wr_be_a[b];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read capture: prediction and compare mask for this cycle's read strobe.
  // The storage arrays still hold the pre-write state here, which gives the
  // read-first behaviour; the write-first build merges the in-flight write.
  // ---------------------------------------------------------------------------
  logic [DW-1:0]        cap_exp  [NUM_BANKS];
  logic [BW-1:0]        cap_mask [NUM_BANKS];
  logic [NUM_BANKS-1:0] uninit_hit;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      cap_exp[b]  = shadow_q[b][rd_set_a[b]];
      cap_mask[b] = written_q[b][rd_set_a[b]];
`ifdef GPR_CHK_WRITE_FIRST_EN
      if (wr_en_i[b] && (wr_set_a[b] == rd_set_a[b])) begin
        for (int j = 0; j < BW; j++) begin
          if (wr_be_a[b][j]) begin
            cap_exp[b][j*8 +: 8] = wr_data_a[b][j*8 +: 8];
          end
        end
        cap_mask[b] = cap_mask[b] | wr_be_a[b];
      end
`endif
      uninit_hit[b] = rd_en_i[b] && (cap_mask[b] != '1);
    end
  end

  // ---------------------------------------------------------------------------
  // Latency pipeline. Only the valid bits are reset; the payload is loaded
  // with the read and simply shifts along behind it.
  // ---------------------------------------------------------------------------
  logic             pipe_vld_q  [NUM_BANKS][RD_LATENCY];
  logic [DW-1:0]    pipe_exp_q  [NUM_BANKS][RD_LATENCY];
  logic [BW-1:0]    pipe_mask_q [NUM_BANKS][RD_LATENCY];
  logic [SET_W-1:0] pipe_set_q  [NUM_BANKS][RD_LATENCY];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int st = 0; st < RD_LATENCY; st++) begin
          pipe_vld_q[b][st] <= 1'b0;
        end
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        pipe_vld_q[b][0] <= rd_en_i[b];
        for (int st = 1; st < RD_LATENCY; st++) begin
          pipe_vld_q[b][st] <= pipe_vld_q[b][st-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rd_en_i[b]) begin
        pipe_exp_q[b][0]  <= cap_exp[b];
        pipe_mask_q[b][0] <= cap_mask[b];
        pipe_set_q[b][0]  <= rd_set_a[b];
      end
      for (int st = 1; st < RD_LATENCY; st++) begin
        pipe_exp_q[b][st]  <= pipe_exp_q[b][st-1];
        pipe_mask_q[b][st] <= pipe_mask_q[b][st-1];
        pipe_set_q[b][st]  <= pipe_set_q[b][st-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Comparator on the final stage. The 4-state !== makes an X or Z in a
  // masked DUT byte count as a mismatch.
  // ---------------------------------------------------------------------------
  logic [NUM_BANKS-1:0] chk_valid_d;
  logic [NUM_BANKS-1:0] chk_mismatch_d;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      chk_valid_d[b]    = pipe_vld_q[b][LAST];
      chk_mismatch_d[b] = 1'b0;
      for (int j = 0; j < BW; j++) begin
        if (pipe_mask_q[b][LAST][j] &&
            (dut_a[b][j*8 +: 8] !== pipe_exp_q[b][LAST][j*8 +: 8])) begin
          chk_mismatch_d[b] = pipe_vld_q[b][LAST];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics and first-error capture
  // ---------------------------------------------------------------------------
  logic [NUM_BANKS-1:0] chk_valid_q;
  logic [NUM_BANKS-1:0] chk_mismatch_q;
  logic                 err_sticky_q,   err_sticky_d;
  logic [EB_W-1:0]      err_bank_q,     err_bank_d;
  logic [SET_W-1:0]     err_set_q,      err_set_d;
  logic [CNT_W-1:0]     check_cnt_q,    check_cnt_d;
  logic [CNT_W-1:0]     error_cnt_q,    error_cnt_d;
  logic [CNT_W-1:0]     uninit_cnt_q,   uninit_cnt_d;

  always_comb begin
    check_cnt_d  = sat_add(check_cnt_q,  popcnt(chk_valid_d));
    error_cnt_d  = sat_add(error_cnt_q,  popcnt(chk_mismatch_d));
    uninit_cnt_d = sat_add(uninit_cnt_q, popcnt(uninit_hit));

    err_sticky_d = err_sticky_q;
    err_bank_d   = err_bank_q;
    err_set_d    = err_set_q;
    if (!err_sticky_q && (|chk_mismatch_d)) begin
      err_sticky_d = 1'b1;
      // Walk downwards so the lowest failing bank is the last one assigned.
      for (int b = NUM_BANKS - 1; b >= 0; b--) begin
        if (chk_mismatch_d[b]) begin
          err_bank_d = EB_W'(b);
          err_set_d  = pipe_set_q[b][LAST];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chk_valid_q    <= '0;
      chk_mismatch_q <= '0;
      err_sticky_q   <= 1'b0;
      err_bank_q     <= '0;
      err_set_q      <= '0;
      check_cnt_q    <= '0;
      error_cnt_q    <= '0;
      uninit_cnt_q   <= '0;
    end else begin
      chk_valid_q    <= chk_valid_d;
      chk_mismatch_q <= chk_mismatch_d;
      err_sticky_q   <= err_sticky_d;
      err_bank_q     <= err_bank_d;
      err_set_q      <= err_set_d;
      check_cnt_q    <= check_cnt_d;
      error_cnt_q    <= error_cnt_d;
      uninit_cnt_q   <= uninit_cnt_d;
    end
  end

  assign chk_valid_o    = chk_valid_q;
  assign chk_mismatch_o = chk_mismatch_q;
  assign err_sticky_o   = err_sticky_q;
  assign err_bank_o     = err_bank_q;
  assign err_set_o      = err_set_q;
  assign check_count_o  = check_cnt_q;
  assign error_count_o  = error_cnt_q;
  assign uninit_count_o = uninit_cnt_q;

endmodule

// File: tb/tb_gpr_bank_shadow_checker.sv
// tb/tb_gpr_bank_shadow_checker.sv - scoreboard bench for gpr_bank_shadow_checker
module tb_gpr_bank_shadow_checker;

  localparam int NB  = 4;
  localparam int NS  = 32;
  localparam int NL  = 4;
  localparam int LW  = 32;
  localparam int RDL = 3;
  localparam int CW  = 16;
  localparam int SW  = 5;
  localparam int DW  = NL * LW;
  localparam int BW  = DW / 8;
  localparam int EBW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NB-1:0]     wr_en;
  logic [NB*SW-1:0]  wr_set;
  logic [NB*DW-1:0]  wr_data;
  logic [NB*BW-1:0]  wr_byteen;
  logic [NB-1:0]     rd_en;
  logic [NB*SW-1:0]  rd_set;
  logic [NB*DW-1:0]  dut_rd_data;
  logic [NB-1:0]     chk_valid;
  logic [NB-1:0]     chk_mismatch;
  logic              err_sticky;
  logic [EBW-1:0]    err_bank;
  logic [SW-1:0]     err_set;
  logic [CW-1:0]     check_count;
  logic [CW-1:0]     error_count;
  logic [CW-1:0]     uninit_count;

  always #5 clk = ~clk;

  gpr_bank_shadow_checker #(
    .NUM_BANKS(NB), .NUM_SETS(NS), .NUM_LANES(NL), .LANE_W(LW),
    .RD_LATENCY(RDL), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .wr_en_i(wr_en), .wr_set_i(wr_set), .wr_data_i(wr_data), .wr_byteen_i(wr_byteen),
    .rd_en_i(rd_en), .rd_set_i(rd_set), .dut_rd_data_i(dut_rd_data),
    .chk_valid_o(chk_valid), .chk_mismatch_o(chk_mismatch),
    .err_sticky_o(err_sticky), .err_bank_o(err_bank), .err_set_o(err_set),
    .check_count_o(check_count), .error_count_o(error_count), .uninit_count_o(uninit_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard
  logic [DW-1:0] m_data [NB][NS];
  logic [BW-1:0] m_wr   [NB][NS];
  int  exp_check, exp_error, exp_uninit;
  bit  m_sticky;
  int  m_err_bank, m_err_set;

  typedef struct { int cyc; int bank; logic mm; } sb_t;
  sb_t sbq [$];

  logic [DW-1:0] sched [8][NB];
  int cyc = 0;

  // Pending per-bank operations for the next step
  logic [NB-1:0] o_wr, o_rd;
  logic [SW-1:0] o_ws [NB];
  logic [SW-1:0] o_rs [NB];
  logic [DW-1:0] o_wd [NB];
  logic [DW-1:0] o_dd [NB];
  logic [BW-1:0] o_be [NB];

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic clear_ops();
    o_wr = '0;
    o_rd = '0;
    for (int b = 0; b < NB; b++) begin
      o_ws[b] = '0; o_rs[b] = '0; o_wd[b] = '0; o_dd[b] = '0; o_be[b] = '0;
    end
  endtask

  // Drive pending ops for the current cycle, update model, advance one clock.
  task automatic step();
    logic [DW-1:0] pred;
    logic [BW-1:0] mask;
    logic          mm;
    for (int b = 0; b < NB; b++) begin
      wr_en[b]              = o_wr[b];
      wr_set[b*SW +: SW]    = o_ws[b];
      wr_data[b*DW +: DW]   = o_wd[b];
      wr_byteen[b*BW +: BW] = o_be[b];
      rd_en[b]              = o_rd[b];
      rd_set[b*SW +: SW]    = o_rs[b];
    end
    for (int b = 0; b < NB; b++) begin
      if (o_rd[b]) begin
        pred = m_data[b][o_rs[b]];
        mask = m_wr[b][o_rs[b]];
`ifdef GPR_CHK_WRITE_FIRST_EN
        if (o_wr[b] && o_ws[b] == o_rs[b]) begin
          for (int j = 0; j < BW; j++)
            if (o_be[b][j]) pred[j*8 +: 8] = o_wd[b][j*8 +: 8];
          mask = mask | o_be[b];
        end
`endif
        mm = 1'b0;
        for (int j = 0; j < BW; j++)
          if (mask[j] && (o_dd[b][j*8 +: 8] !== pred[j*8 +: 8])) mm = 1'b1;
        sbq.push_back('{cyc: cyc + RDL + 1, bank: b, mm: mm});
        sched[(cyc + RDL) % 8][b] = o_dd[b];
        exp_check = sat(exp_check + 1);
        if (mm) exp_error = sat(exp_error + 1);
        if (mask != '1) exp_uninit = sat(exp_uninit + 1);
        if (mm && !m_sticky) begin
          m_sticky   = 1'b1;
          m_err_bank = b;
          m_err_set  = int'(o_rs[b]);
        end
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (o_wr[b]) begin
        for (int j = 0; j < BW; j++)
          if (o_be[b][j]) m_data[b][o_ws[b]][j*8 +: 8] = o_wd[b][j*8 +: 8];
        m_wr[b][o_ws[b]] = m_wr[b][o_ws[b]] | o_be[b];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    wr_en = '0;
    rd_en = '0;
    for (int b = 0; b < NB; b++) begin
      dut_rd_data[b*DW +: DW] = sched[cyc % 8][b];
      sched[cyc % 8][b] = '0;
    end
    clear_ops();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sbq.delete();
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < NB; b++) sched[i][b] = '0;
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++) m_wr[b][s] = '0;
    exp_check = 0; exp_error = 0; exp_uninit = 0;
    m_sticky = 1'b0; m_err_bank = 0; m_err_set = 0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (RDL + 2) step();
    check({tag, "_sb_empty"}, DW'(sbq.size()), '0);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_check_count"},  check_count,  DW'(exp_check));
    check({tag, "_error_count"},  error_count,  DW'(exp_error));
    check({tag, "_uninit_count"}, uninit_count, DW'(exp_uninit));
    check({tag, "_err_sticky"},   err_sticky,   DW'(m_sticky));
    check({tag, "_err_bank"},     err_bank,     DW'(m_err_bank));
    check({tag, "_err_set"},      err_set,      DW'(m_err_set));
  endtask

  // Monitor: every reported comparison must match the head of the scoreboard.
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (chk_mismatch[b] && !chk_valid[b]) check("mismatch_without_valid", 1'b1, 1'b0);
      if (chk_valid[b]) begin
        if (sbq.size() == 0) begin
          check("spurious_chk_valid", DW'(b), DW'(NB));
        end else begin
          sb_t e;
          e = sbq.pop_front();
          check("sb_bank",     DW'(b),          DW'(e.bank));
          check("sb_latency",  DW'(cyc),        DW'(e.cyc));
          check("sb_mismatch", chk_mismatch[b], e.mm);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [DW-1:0] v;
  int s;

  initial begin
    reset = 1'b1; wr_en = '0; wr_set = '0; wr_data = '0; wr_byteen = '0;
    rd_en = '0; rd_set = '0; dut_rd_data = '0;
    clear_ops();
    do_reset();

    check("rst_chk_valid",    chk_valid,    '0);
    check("rst_chk_mismatch", chk_mismatch, '0);
    check_stats("rst");

    // 1: full write then matching read
    o_wr[0] = 1'b1; o_ws[0] = 5'd3; o_wd[0] = {4{32'h11223344}}; o_be[0] = '1;
    step();
    o_rd[0] = 1'b1; o_rs[0] = 5'd3; o_dd[0] = {4{32'h11223344}};
    step();
    drain("t1");
    check_stats("t1");
    check("t1_check_count_const", check_count, DW'(1));

    // 2: lane0-only write, DUT garbage in unwritten lanes
    o_wr[1] = 1'b1; o_ws[1] = 5'd5; o_wd[1] = {4{32'hCAFEF00D}}; o_be[1] = 16'h000F;
    step();
    o_rd[1] = 1'b1; o_rs[1] = 5'd5; o_dd[1] = {96'hDEADBEEF_01234567_89ABCDEF, 32'hCAFEF00D};
    step();
    drain("t2");
    check_stats("t2");
    check("t2_uninit_const", uninit_count, DW'(1));

    // 3: lane2 bit0 flipped
    o_rd[0] = 1'b1; o_rs[0] = 5'd3; o_dd[0] = {4{32'h11223344}} ^ (DW'(1) << 64);
    step();
    drain("t3");
    check_stats("t3");
    check("t3_err_set_const", err_set, DW'(3));

    // 4: banks 2 and 3 mismatch for 4 back-to-back cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int b = 2; b < 4; b++) begin
        o_wr[b] = 1'b1; o_ws[b] = SW'(i); o_be[b] = '1;
        o_wd[b] = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      for (int b = 2; b < 4; b++) begin
        o_rd[b] = 1'b1; o_rs[b] = SW'(i);
        o_dd[b] = m_data[b][i] ^ (DW'(1) << (i * 8 + b));
      end
      step();
    end
    drain("t4");
    check_stats("t4");
    check("t4_error_count_const", error_count, DW'(8));
    check("t4_err_bank_const",    err_bank,    DW'(2));

    // 5: same-cycle write and read of bank0 set7
    o_wr[0] = 1'b1; o_ws[0] = 5'd7; o_wd[0] = {8{16'h5555}}; o_be[0] = '1;
    step();
    o_wr[0] = 1'b1; o_ws[0] = 5'd7; o_wd[0] = {8{16'hAAAA}}; o_be[0] = '1;
    o_rd[0] = 1'b1; o_rs[0] = 5'd7; o_dd[0] = {8{16'h5555}};
    step();
    o_rd[0] = 1'b1; o_rs[0] = 5'd7; o_dd[0] = {8{16'hAAAA}};
    step();
    drain("t5");
    check_stats("t5");

    // 6: reset with two reads in flight, then re-read a previously written set
    o_wr[1] = 1'b1; o_ws[1] = 5'd9; o_wd[1] = {4{32'h0BADF00D}}; o_be[1] = '1;
    step();
    o_rd[1] = 1'b1; o_rs[1] = 5'd9; o_dd[1] = '0;
    step();
    o_rd[1] = 1'b1; o_rs[1] = 5'd9; o_dd[1] = '0;
    step();
    do_reset();
    repeat (RDL + 3) step();
    check_stats("t6_after_reset");
    check("t6_check_count_zero", check_count, '0);
    o_rd[1] = 1'b1; o_rs[1] = 5'd9; o_dd[1] = {4{32'h12345678}};
    step();
    drain("t6");
    check_stats("t6");
    check("t6_uninit_const", uninit_count, DW'(1));

    // Saturation: four mismatching reads per cycle well past 2^CNT_W-1
    do_reset();
    for (int i = 0; i < NS; i++) begin
      for (int b = 0; b < NB; b++) begin
        o_wr[b] = 1'b1; o_ws[b] = SW'(i); o_be[b] = '1;
        o_wd[b] = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    for (int i = 0; i < 16400; i++) begin
      for (int b = 0; b < NB; b++) begin
        s = $urandom_range(0, NS - 1);
        v = m_data[b][s] ^ (DW'(1) << $urandom_range(0, DW - 1));
        o_rd[b] = 1'b1; o_rs[b] = SW'(s); o_dd[b] = v;
      end
      step();
    end
    drain("sat");
    check_stats("sat");
    check("sat_check_count_max", check_count, DW'(CMAX));
    check("sat_error_count_max", error_count, DW'(CMAX));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
